// File: rtl/mips_fetch_queue.sv
// mips_fetch_queue: instruction fetch front end for the MIPS core.
// Issues sequential fetch requests to a synchronous-read instruction memory.
// Returned words are buffered with their PCs in a DEPTH-entry prefetch queue,
// and the queue feeds decode through a valid/ready handshake. A redirect
// flushes the queue, squashes the in-flight response and restarts fetch.
// Fetch is credit-driven: a request goes out only when the queue is
// guaranteed to have room for its response.
// DEPTH must be a power of two and at least 2.
// Optional feature: define FETCHQ_PERF_EN to add the perf_fetched and
// perf_stall counter outputs.
module mips_fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
`ifdef FETCHQ_PERF_EN
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_stall,
`endif
    output logic [31:0] id_pc_plus4
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW+1:0] DEPTH_C = DEPTH[PW+1:0];

    logic [31:0] fpc;
    logic        pending;
    logic [31:0] rspPc;
    logic [PW-1:0] rdPtr;
    logic [PW-1:0] wrPtr;
    logic [PW:0]   count;
    logic [PW+1:0] credit;
    logic          push;
    logic          pop;

    logic [31:0] qInstr [DEPTH];
    logic [31:0] qPc    [DEPTH];

    // Credit check: queued entries plus the response still in flight.
    assign credit    = {1'b0, count} + {{(PW+1){1'b0}}, pending};
    assign imem_req  = !reset && !redirect && (credit < DEPTH_C);
    assign imem_addr = fpc;

    assign id_valid  = (count != '0) && !redirect;
    assign push      = pending && !redirect;
    assign pop       = id_valid && id_ready;

    // Head fields are forced to zero whenever the head is not valid.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        id_instr    = 32'h0;
        id_pc       = 32'h0;
        id_pc_plus4 = 32'h0;
        if (id_valid) begin
            id_instr    = qInstr[rdPtr];
            id_pc       = qPc[rdPtr];
            id_pc_plus4 = qPc[rdPtr] + 32'd4;
        end
    end

    // Fetch PC, response tracking, pointers and occupancy.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            fpc     <= RESET_PC;
            pending <= 1'b0;
            rspPc   <= 32'h0;
            rdPtr   <= '0;
            wrPtr   <= '0;
            count   <= '0;
        end else if (redirect) begin
            fpc     <= redirect_pc;
            pending <= 1'b0;
            rdPtr   <= '0;
            wrPtr   <= '0;
            count   <= '0;
        end else begin
            if (imem_req) begin
                pending <= 1'b1;
                rspPc   <= fpc;
                fpc     <= fpc + 32'd4;
            end else begin
                pending <= 1'b0;
            end
            if (push) wrPtr <= wrPtr + 1'b1;
            if (pop)  rdPtr <= rdPtr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Queue storage: write the returning word and its PC at the tail.
    always_ff @(posedge clk) begin
        // NOTE: storage has no reset; pointers and count alone decide which entries are live.
        if (push && !reset) begin
            qInstr[wrPtr] <= imem_rdata;
            qPc[wrPtr]    <= rspPc;
        end
    end

`ifdef FETCHQ_PERF_EN
    // Performance counters: pushes, and cycles with nothing to hand to decode.
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_fetched <= 32'h0;
            perf_stall   <= 32'h0;
        end else begin
            if (push)                   perf_fetched <= perf_fetched + 32'd1;
            if (!id_valid && !redirect) perf_stall   <= perf_stall + 32'd1;
        end
    end
`else
    // Counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_mips_fetch_queue.sv
// tb_mips_fetch_queue: directed self-checking bench for mips_fetch_queue
// (DEPTH=4, RESET_PC=0). The memory model returns word k at byte address 4k,
// one cycle after the request. Inputs change 1 time unit after the rising
// edge; outputs are sampled 1-2 time units after that.
module tb_mips_fetch_queue;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [31:0] id_pc_plus4;
`ifdef FETCHQ_PERF_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_stall;
`endif

    int nChecks = 0;
    int nFails  = 0;

    always #5 clk = ~clk;

    mips_fetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .id_valid    (id_valid),
        .id_ready    (id_ready),
        .id_instr    (id_instr),
        .id_pc       (id_pc),
`ifdef FETCHQ_PERF_EN
        .perf_fetched(perf_fetched),
        .perf_stall  (perf_stall),
`endif
        .id_pc_plus4 (id_pc_plus4)
    );

    // Synchronous-read instruction memory: word k holds the value k.
    always @(posedge clk) begin
        if (imem_req) imem_rdata <= {2'b00, imem_addr[31:2]};
    end

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nFails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Entered in cycle 0 (reset just released, id_ready=1): one word per cycle.
    task automatic streamCheck(input string sc);
        for (int c = 0; c <= 12; c++) begin
            #1;
            check($sformatf("%s req c%0d", sc, c), {31'h0, imem_req}, 32'd1);
            check($sformatf("%s addr c%0d", sc, c), imem_addr, 32'(4 * c));
            check($sformatf("%s valid c%0d", sc, c), {31'h0, id_valid}, (c >= 2) ? 32'd1 : 32'd0);
            if (c >= 2) begin
                check($sformatf("%s pc c%0d", sc, c), id_pc, 32'(4 * (c - 2)));
                check($sformatf("%s instr c%0d", sc, c), id_instr, 32'(c - 2));
                check($sformatf("%s pc4 c%0d", sc, c), id_pc_plus4, 32'(4 * (c - 1)));
            end
`ifdef FETCHQ_PERF_EN
            if (c == 12) begin
                check($sformatf("%s perf_fetched>=10", sc), {31'h0, (perf_fetched >= 32'd10)}, 32'd1);
                check($sformatf("%s perf_stall", sc), perf_stall, 32'd2);
            end
`endif
            tick();
        end
    endtask

    initial begin
        int reqs;
        reset       = 1'b1;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        id_ready    = 1'b1;

        // Reset values.
        repeat (3) tick();
        #1;
        check("rst req", {31'h0, imem_req}, 32'd0);
        check("rst addr", imem_addr, 32'h0);
        check("rst valid", {31'h0, id_valid}, 32'd0);
        check("rst instr", id_instr, 32'h0);
        check("rst pc", id_pc, 32'h0);
        check("rst pc4", id_pc_plus4, 32'h0);

        // Scenario 1: streaming with id_ready held high.
        reset = 1'b0;
        streamCheck("s1");

        // Scenario 2: decode stalled from cycle 0, queue fills to exactly DEPTH.
        reset    = 1'b1;
        id_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        reqs  = 0;
        for (int c = 0; c < 8; c++) begin
            #1;
            if (imem_req) begin
                check($sformatf("s2 addr req%0d", reqs), imem_addr, 32'(4 * reqs));
                reqs++;
            end
            tick();
        end
        check("s2 req count", 32'(reqs), 32'd4);
        #1;
        check("s2 full valid", {31'h0, id_valid}, 32'd1);
        check("s2 full head", id_pc, 32'h0);
        id_ready = 1'b1;
        for (int i = 0; i <= 4; i++) begin
            #1;
            check($sformatf("s2 drain pc%0d", i), id_pc, 32'(4 * i));
            check($sformatf("s2 drain instr%0d", i), id_instr, 32'(i));
            if (i == 0) check("s2 no credit on pop", {31'h0, imem_req}, 32'd0);
            if (i == 1) begin
                check("s2 resume req", {31'h0, imem_req}, 32'd1);
                check("s2 resume addr", imem_addr, 32'd16);
            end
            tick();
        end

        // Scenario 3: redirect with 3 entries queued and a response pending.
        reset    = 1'b1;
        id_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        repeat (4) tick();
        #1;
        check("s3 pre valid", {31'h0, id_valid}, 32'd1);
        redirect    = 1'b1;
        redirect_pc = 32'h40;
        #1;
        check("s3 r valid", {31'h0, id_valid}, 32'd0);
        check("s3 r req", {31'h0, imem_req}, 32'd0);
        tick();
        redirect = 1'b0;
        #1;
        check("s3 r+1 req", {31'h0, imem_req}, 32'd1);
        check("s3 r+1 addr", imem_addr, 32'h40);
        check("s3 r+1 valid", {31'h0, id_valid}, 32'd0);
        tick();
        #1;
        check("s3 r+2 valid", {31'h0, id_valid}, 32'd0);
        tick();
        #1;
        check("s3 r+3 valid", {31'h0, id_valid}, 32'd1);
        check("s3 r+3 pc", id_pc, 32'h40);
        check("s3 r+3 instr", id_instr, 32'h10);
        id_ready = 1'b1;
        tick();
        #1;
        check("s3 r+4 pc", id_pc, 32'h44);
        check("s3 r+4 instr", id_instr, 32'h11);
        tick();
        #1;
        check("s3 r+5 pc", id_pc, 32'h48);

        // Scenario 4: redirect to the top of the address space; PC wraps.
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        #1;
        check("s4 r valid", {31'h0, id_valid}, 32'd0);
        tick();
        redirect = 1'b0;
        #1;
        check("s4 r+1 req", {31'h0, imem_req}, 32'd1);
        check("s4 r+1 addr", imem_addr, 32'hFFFF_FFFC);
        tick();
        #1;
        check("s4 r+2 req", {31'h0, imem_req}, 32'd1);
        check("s4 r+2 wrap addr", imem_addr, 32'h0);
        tick();
        #1;
        check("s4 r+3 valid", {31'h0, id_valid}, 32'd1);
        check("s4 r+3 pc", id_pc, 32'hFFFF_FFFC);
        check("s4 r+3 pc4", id_pc_plus4, 32'h0);
        check("s4 r+3 instr", id_instr, 32'h3FFF_FFFF);
        tick();
        #1;
        check("s4 r+4 pc", id_pc, 32'h0);
        check("s4 r+4 pc4", id_pc_plus4, 32'h4);

        // Back-to-back redirects: the last target wins.
        redirect    = 1'b1;
        redirect_pc = 32'h100;
        tick();
        redirect_pc = 32'h200;
        #1;
        check("b2b r+1 req", {31'h0, imem_req}, 32'd0);
        check("b2b r+1 valid", {31'h0, id_valid}, 32'd0);
        tick();
        redirect = 1'b0;
        #1;
        check("b2b addr", imem_addr, 32'h200);
        tick();
        tick();
        #1;
        check("b2b head pc", id_pc, 32'h200);

        // Scenario 5: reset with a full queue, then scenario 1 again.
        id_ready = 1'b0;
        repeat (6) tick();
        #1;
        check("s5 full valid", {31'h0, id_valid}, 32'd1);
        check("s5 full no req", {31'h0, imem_req}, 32'd0);
        reset = 1'b1;
        tick();
        reset    = 1'b0;
        id_ready = 1'b1;
        streamCheck("s5");

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/mips_fetch_queue.md
# mips_fetch_queue

Instruction fetch front end for the MIPS core: generates sequential fetch addresses, drives a synchronous-read instruction memory, and buffers returned words with their PCs in a small prefetch queue. The queue feeds the decode stage through a valid/ready handshake. Decode can stall without losing instructions, and a branch/jump redirect from execute flushes the queue and restarts fetch at the target.

## Interface
- DEPTH, 4, queue entries; power of two, minimum 2
- RESET_PC, 32'h0000_0000, first fetch address after reset

- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-high; sampled on the rising edge of clk
- imem_req  out  1  fetch request this cycle
- imem_addr  out  32  byte address of the request; word = imem_addr[31:2]
- imem_rdata  in  32  instruction word; valid exactly one cycle after imem_req
- redirect  in  1  flush and restart fetch (taken branch/jump)
- redirect_pc  in  32  restart address, used when redirect=1
- id_valid  out  1  queue head holds a valid instruction
- id_ready  in  1  decode accepts the head this cycle
- id_instr  out  32  head instruction word
- id_pc  out  32  head instruction address
- id_pc_plus4  out  32  id_pc + 4, mod 2^32

## Operation
- State: fetch PC `fpc`, a response-pending flag with captured `rsp_pc`, a DEPTH-entry queue of {instr, pc}, and read/write pointers of log2(DEPTH) bits that wrap naturally. Occupancy count runs 0..DEPTH.
- The block has no FSM. It is credit-driven.
- imem_req = !reset && !redirect && (count + pending < DEPTH). Pops in the same cycle grant no credit.
- imem_addr = fpc, combinationally.
- On imem_req:
  - pending <= 1, rsp_pc <= fpc.
  - fpc <= fpc + 4 (wraps at 2^32; low two bits are carried unchanged and never checked).
- Otherwise pending <= 0.
- When pending=1 and no redirect: push {imem_rdata, rsp_pc} at the write pointer.
- Pop occurs when id_valid && id_ready.
- Push and pop in the same cycle leave count unchanged.
- Overflow cannot occur by construction. Underflow cannot occur because id_valid=0 when empty.
- id_valid = (count != 0) && !redirect.
- id_instr, id_pc and id_pc_plus4 show the head entry when id_valid=1, and are driven to 0 when id_valid=0.
- Redirect (priority over all except reset):
  - count and pointers go to 0.
  - The pending response is squashed: not pushed, pending <= 0.
  - fpc <= redirect_pc.
  - imem_req=0 and no pop occurs in that cycle.
- Redirect asserted in consecutive cycles: the last redirect_pc wins.
- Reset:
  - fpc <= RESET_PC; count, pointers and pending <= 0.
  - Reset mid-operation discards queue contents and any in-flight response.

## Timing
- Reset values: imem_req=0, imem_addr=RESET_PC, id_valid=0, id_instr=0, id_pc=0, id_pc_plus4=0.
- Cycle 0 is the first cycle with reset=0:
  - cycle 0: imem_req=1, addr=RESET_PC.
  - cycle 1: rdata captured.
  - cycle 2: id_valid=1.
- Fetch-to-decode latency is 2 cycles.
- Redirect in cycle r:
  - cycle r+1: imem_req with addr=redirect_pc.
  - cycle r+3: id_valid=1 with id_pc=redirect_pc.
- Throughput with id_ready held high is 1 instruction/cycle when DEPTH≥3. DEPTH=2 gives 1 per 2 cycles.
- With id_ready low, requests stop once count + pending = DEPTH. The queue fills to exactly DEPTH with no lost or duplicated words.
- id_valid and head fields are stable while id_valid=1 and id_ready=0, unless a redirect occurs.

## Configuration
- FETCHQ_PERF_EN defined: add outputs perf_fetched (32, count of pushes) and perf_stall (32, cycles with id_valid=0 and no redirect or reset).
  - Both are cleared by reset and wrap at 2^32.
  - Neither is cleared by redirect.
- Undefined: these ports and counters do not exist. All other behaviour is identical.

## Test plan
- Reset release, memory word k = k, id_ready=1, DEPTH=4 → id_valid rises cycle 2 with id_pc=0, id_instr=0; then id_pc 4, 8, 12… one per cycle; id_pc_plus4 = id_pc+4.
- id_ready=0 from cycle 0 → exactly 4 requests (addr 0, 4, 8, 12), then imem_req=0. After id_ready=1, heads appear in order 0, 4, 8, 12 and fetch resumes at 16.
- Redirect to 0x40 while the queue holds 3 entries and a response is pending → id_valid=0 that cycle; cycle r+1 addr=0x40; cycle r+3 id_pc=0x40. Stale entries never appear at the head.
- Redirect to 0xFFFF_FFFC → next head pc=0xFFFF_FFFC with id_pc_plus4=0; the following fetch address is 0x0.
- Reset asserted mid-stream with a full queue → next cycle id_valid=0 and imem_addr=RESET_PC; after release the behaviour repeats scenario 1.
- With FETCHQ_PERF_EN: 10 accepted instructions after reset → perf_fetched ≥ 10 and perf_stall=2 (cycles 0–1).
